// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file's single write port among
// NUM_REQ requesters, plus a 32-cycle clear sequence that zeroes every register.
module regfile_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 64,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*5-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic [4:0]                writeRegister,
    output logic                      regWrite,
    output logic [DATA_W-1:0]         writeData,
    output logic [2:0]                grant_id
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [4:0]          wreg_q, wreg_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          gid_q, gid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [2*NUM_REQ-1:0] vv;
    logic                 gnt_found;
    logic [2:0]           gnt_idx;
    logic                 arb_en;
    logic [4:0]           sel_addr;
    logic [DATA_W-1:0]    sel_data;

    function automatic logic [2:0] wrap_idx(input logic [2:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return 3'(s);
    endfunction

    // Rotating the doubled valid vector by ptr makes the first set bit the winner.
    always_comb begin
        vv        = {req_valid, req_valid} >> ptr_q;
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && vv[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(ptr_q, k);
            end
        end
    end

    assign arb_en = (state_q == IDLE) && !clear_start;

    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_found && (gnt_idx == 3'(i))) begin
                req_ready[i] = arb_en;
                sel_addr     = req_addr[i*5 +: 5];
                sel_data     = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        wen_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (gnt_found) begin
                    ptr_d   = wrap_idx(gnt_idx, 1);
                    wreg_d  = sel_addr;
                    wdata_d = sel_data;
                    gid_d   = gnt_idx;
                    // Register 31 is hardwired zero: accept the write but drop it.
                    wen_d   = !(ZERO_REG && (sel_addr == 5'd31));
                end
            end
            CLEAR: begin
                wen_d   = 1'b1;
                wreg_d  = cnt_q;
                wdata_d = '0;
                gid_d   = '0;
                if (cnt_q == 5'd31) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q + 5'd1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            wreg_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wreg_q  <= wreg_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign writeRegister = wreg_q;
    assign regWrite      = wen_q;
    assign writeData     = wdata_q;
    assign grant_id      = gid_q;
    assign clear_busy    = busy_q;
    assign clear_done    = done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: two arbiters (ZERO_REG=1 and ZERO_REG=0) share stimulus;
// a round-robin reference model predicts grants and register-file writes.
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [63:0] d;
        logic [2:0]  g;
        bit          done;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req_valid;
    logic [N*5-1:0]  req_addr;
    logic [N*DW-1:0] req_data;
    logic          clear_start;

    logic [N-1:0]  rdy0, rdy1;
    logic          busy0, busy1, done0, done1, we0, we1;
    logic [4:0]    wr0, wr1;
    logic [DW-1:0] wd0, wd1;
    logic [2:0]    gid0, gid1;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ZERO_REG(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(rdy0), .clear_start(clear_start),
        .clear_busy(busy0), .clear_done(done0), .writeRegister(wr0),
        .regWrite(we0), .writeData(wd0), .grant_id(gid0));

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ZERO_REG(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(rdy1), .clear_start(clear_start),
        .clear_busy(busy1), .clear_done(done1), .writeRegister(wr1),
        .regWrite(we1), .writeData(wd1), .grant_id(gid1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q[2][$];

    // reference model state
    int   m_ptr   = 0;
    bit   m_clear = 1'b0;
    int   m_c     = 0;
    int   last_gnt;
    bit          pend_v[N];
    logic [4:0]  pend_a[N];
    logic [63:0] pend_d[N];

    // outputs as seen at the start of the most recent step
    logic        snap_we0, snap_we1, snap_done0, snap_busy0;
    logic [4:0]  snap_wr0, snap_wr1;
    logic [63:0] snap_wd0;
    logic [2:0]  snap_gid0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic scan(input int w, input logic we, input logic [4:0] a,
                        input logic [63:0] d, input logic [2:0] g, input logic dn);
        exp_t e;
        while (q[w].size() > 0 && q[w][0].cyc < cyc) begin
            e = q[w].pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d missed_write: got no write, expected reg %0d in cycle %0d", w, e.a, e.cyc);
        end
        if (we) begin
            n_tests++;
            if (q[w].size() == 0) begin
                n_fail++;
                $display("FAIL dut%0d unexpected_write: got reg %0d data %0h in cycle %0d, expected no write", w, a, d, cyc);
            end else begin
                e = q[w].pop_front();
                if (e.cyc != cyc || e.a !== a || e.d !== d || e.g !== g || e.done !== dn) begin
                    n_fail++;
                    $display("FAIL dut%0d write: got cyc %0d reg %0d data %0h gid %0d done %0b, expected cyc %0d reg %0d data %0h gid %0d done %0b",
                             w, cyc, a, d, g, dn, e.cyc, e.a, e.d, e.g, e.done);
                end
            end
        end else if (dn) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d clear_done: got 1 without a write, expected 0 (cycle %0d)", w, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            scan(0, we0, wr0, wd0, gid0, done0);
            scan(1, we1, wr1, wd1, gid1, done1);
        end
    end

    task automatic new_req(input int i);
        pend_v[i] = 1'b1;
        pend_a[i] = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom % 32);
        pend_d[i] = {$urandom, $urandom};
    endtask

    task automatic step(input bit cs, input bit refill);
        logic [N-1:0] exp_rdy;
        int g;
        int idx;
        exp_t e;
        @(posedge clk);
        #1;
        snap_we0 = we0; snap_wr0 = wr0; snap_wd0 = wd0; snap_gid0 = gid0;
        snap_done0 = done0; snap_busy0 = busy0; snap_we1 = we1; snap_wr1 = wr1;
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = pend_v[i];
            req_addr[i*5 +: 5]   = pend_a[i];
            req_data[i*DW +: DW] = pend_d[i];
        end
        clear_start = cs;
        #1;
        exp_rdy = '0;
        g = -1;
        if (!m_clear && !cs) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && pend_v[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready0", 64'(rdy0), 64'(exp_rdy));
        chk("ready1", 64'(rdy1), 64'(exp_rdy));
        chk("clear_busy", 64'(busy0), 64'(m_clear));
        last_gnt = -1;
        if (m_clear) begin
            e.cyc = cyc + 1; e.a = 5'(m_c); e.d = '0; e.g = '0; e.done = (m_c == 31);
            q[0].push_back(e);
            q[1].push_back(e);
            if (m_c == 31) m_clear = 1'b0;
            else m_c++;
        end else if (cs) begin
            m_clear = 1'b1;
            m_c     = 0;
        end else if (g >= 0) begin
            e.cyc = cyc + 1; e.a = pend_a[g]; e.d = pend_d[g]; e.g = 3'(g); e.done = 1'b0;
            q[1].push_back(e);
            if (pend_a[g] != 5'd31) q[0].push_back(e);
            m_ptr     = (g + 1) % N;
            last_gnt  = g;
            pend_v[g] = 1'b0;
            if (refill) new_req(g);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n     = 1'b0;
        req_valid   = '0;
        clear_start = 1'b0;
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        q[0].delete();
        q[1].delete();
        m_ptr = 0; m_clear = 1'b0; m_c = 0;
        #1;
        chk("rst_regWrite", 64'(we0), 64'(0));
        chk("rst_regWrite1", 64'(we1), 64'(0));
        chk("rst_busy", 64'(busy0), 64'(0));
        chk("rst_done", 64'(done0), 64'(0));
        chk("rst_writeRegister", 64'(wr0), 64'(0));
        chk("rst_writeData", wd0, 64'(0));
        chk("rst_grant_id", 64'(gid0), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        clear_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0; pend_a[i] = '0; pend_d[i] = '0;
        end
        do_reset();

        // single request, one-cycle write latency
        pend_v[0] = 1'b1; pend_a[0] = 5'd3; pend_d[0] = 64'hAA;
        step(1'b0, 1'b0);
        chk("t1_grant", 64'(last_gnt), 64'(0));
        step(1'b0, 1'b0);
        chk("t1_regWrite", 64'(snap_we0), 64'(1));
        chk("t1_writeRegister", 64'(snap_wr0), 64'(3));
        chk("t1_writeData", snap_wd0, 64'hAA);
        chk("t1_grant_id", 64'(snap_gid0), 64'(0));

        // all requesters continuously valid: strict rotation
        do_reset();
        for (int i = 0; i < N; i++) new_req(i);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            chk("t2_rotation", 64'(last_gnt), 64'(i % N));
        end

        // clear beats pending requests; pointer survives the clear
        step(1'b1, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("t3_post_clear_grant", 64'(last_gnt), 64'(0));
        chk("t3_last_write_reg", 64'(snap_wr0), 64'(31));
        chk("t3_clear_done", 64'(snap_done0), 64'(1));
        chk("t3_busy_dropped", 64'(snap_busy0), 64'(0));

        // write to register 31 with and without the zero register
        do_reset();
        pend_v[2] = 1'b1; pend_a[2] = 5'd31; pend_d[2] = 64'h1234_5678_9ABC_DEF0;
        step(1'b0, 1'b0);
        chk("t4_grant", 64'(last_gnt), 64'(2));
        step(1'b0, 1'b0);
        chk("t4_zero_reg_dropped", 64'(snap_we0), 64'(0));
        chk("t4_plain_reg31_write", 64'(snap_we1), 64'(1));
        chk("t4_plain_reg31_addr", 64'(snap_wr1), 64'(31));

        // reset in the middle of a clear, then normal operation
        step(1'b1, 1'b0);
        while (!(m_clear && m_c == 10)) step(1'b0, 1'b0);
        do_reset();
        pend_v[0] = 1'b1; pend_a[0] = 5'd4; pend_d[0] = 64'h55;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t5_regWrite", 64'(snap_we0), 64'(1));
        chk("t5_writeRegister", 64'(snap_wr0), 64'(4));
        chk("t5_writeData", snap_wd0, 64'h55);

        // randomized traffic with occasional clears and resets
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++)
                if (!pend_v[i] && ($urandom % 2 == 0)) new_req(i);
            if ($urandom % 200 == 0) do_reset();
            else step(($urandom % 40) == 0, 1'b0);
        end

        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        while (m_clear) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        @(negedge clk);
        chk("drain_q0", 64'(q[0].size()), 64'(0));
        chk("drain_q1", 64'(q[1].size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
